spi_command_sequencer: RTL and testbench

- Upstream feeder for spi_master (N=10 slaves, C=16-bit words). Replaces the free-running spi_programmer with a host-loadable command queue.
- Host pushes {slave index, mode, data word} into a FIFO. The sequencer pops each entry and drives din/target/CPOL/CPHA/trigger into spi_master.
- It tracks spi_master's valid handshake, captures dout, and returns one response per command through a valid/ready port, with error reporting for bad indices and timeouts.

---
 rtl/spi_command_sequencer.sv | 217 +++++++++++++++++++++
 tb/tb_spi_command_sequencer.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_command_sequencer.sv
// Host-loadable command queue feeding spi_master: pops {slave, mode, data} entries,
// runs one SPI transfer per entry and returns one response (data or error) per command.
module spi_command_sequencer #(
  parameter int N       = 10,
  parameter int C       = 16,
  parameter int SW      = 4,
  parameter int AW      = 3,
  parameter int TIMEOUT = 4096
) (
  input  logic          CLK_IN,
  input  logic          RST_IN,
  input  logic [C-1:0]  cmd_data,
  input  logic [SW-1:0] cmd_slave,
  input  logic [1:0]    cmd_mode,
  input  logic          cmd_wr,
  output logic          cmd_full,
  output logic [AW:0]   cmd_count,
  output logic          cmd_ovf,
  output logic [C-1:0]  rsp_data,
  output logic [SW-1:0] rsp_slave,
  output logic          rsp_err,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic          busy,
  output logic [C-1:0]  din,
  output logic [N-1:0]  target,
  output logic          trigger,
  output logic          CPOL,
  output logic          CPHA,
  input  logic          valid,
  input  logic [C-1:0]  dout
);

  localparam int DEPTH = 2 ** AW;
  localparam int EW    = C + SW + 2;
  localparam int TW    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_TRIG,
    S_WAIT_ACK,
    S_WAIT_DONE,
    S_RESP
  } state_t;

  // FIFO storage and pointers
  logic [EW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          ovf_q;
  logic          full;
  logic          push;
  logic          pop;

  logic [EW-1:0] head;
  logic [SW-1:0] head_slave;
  logic [1:0]    head_mode;
  logic [C-1:0]  head_data;
  logic [N-1:0]  head_onehot;

  // Sequencer registers
  state_t        state_q;
  logic [C-1:0]  din_q;
  logic [N-1:0]  target_q;
  logic          trigger_q;
  logic          cpol_q;
  logic          cpha_q;
  logic [SW-1:0] slave_q;
  logic [C-1:0]  rsp_data_q;
  logic          rsp_err_q;
  logic          rsp_valid_q;
  logic [TW-1:0] tmo_q;
  logic [TW-1:0] tmo_inc;

  // Full is judged on the pre-pop occupancy, so a push into a full queue is lost
  // even when the sequencer pops in the same cycle.
  assign full = (count_q == (AW+1)'(DEPTH));
  assign push = cmd_wr && !full;
  assign pop  = (state_q == S_IDLE) && (count_q != '0);

  assign head = mem_q[rd_ptr_q];
  assign {head_slave, head_mode, head_data} = head;

  // An out-of-range index decodes to an all-zero select, which doubles as the error flag.
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_onehot
      assign head_onehot[gi] = (head_slave == SW'(gi));
    end
  endgenerate

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q + (AW+1)'(push) - (AW+1)'(pop);
  end

  always_ff @(posedge CLK_IN) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {cmd_slave, cmd_mode, cmd_data};
    end
  end

  always_ff @(posedge CLK_IN) begin
    if (RST_IN) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (cmd_wr && full) begin
        ovf_q <= 1'b1;
      end
    end
  end

  assign tmo_inc = tmo_q + TW'(1);

  always_ff @(posedge CLK_IN) begin
    if (RST_IN) begin
      state_q     <= S_IDLE;
      din_q       <= '0;
      target_q    <= '0;
      trigger_q   <= 1'b0;
      cpol_q      <= 1'b0;
      cpha_q      <= 1'b0;
      slave_q     <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      tmo_q       <= '0;
    end else begin
      trigger_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (pop) begin
            din_q    <= head_data;
            cpol_q   <= head_mode[1];
            cpha_q   <= head_mode[0];
            slave_q  <= head_slave;
            target_q <= head_onehot;
            if (|head_onehot) begin
              state_q <= S_SETUP;
            end else begin
              rsp_data_q  <= '0;
              rsp_err_q   <= 1'b1;
              rsp_valid_q <= 1'b1;
              state_q     <= S_RESP;
            end
          end
        end
        S_SETUP: begin
          trigger_q <= 1'b1;
          state_q   <= S_TRIG;
        end
        S_TRIG: begin
          tmo_q   <= '0;
          state_q <= S_WAIT_ACK;
        end
        S_WAIT_ACK: begin
          tmo_q <= tmo_inc;
          if (tmo_inc == TMO_LAST) begin
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b1;
            rsp_valid_q <= 1'b1;
            state_q     <= S_RESP;
          end else if (!valid) begin
            state_q <= S_WAIT_DONE;
          end
        end
        S_WAIT_DONE: begin
          tmo_q <= tmo_inc;
          // A completion on the last allowed cycle still wins over the timeout.
          if (valid) begin
            rsp_data_q  <= dout;
            rsp_err_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            state_q     <= S_RESP;
          end else if (tmo_inc == TMO_LAST) begin
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b1;
            rsp_valid_q <= 1'b1;
            state_q     <= S_RESP;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            target_q    <= '0;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign cmd_full  = full;
  assign cmd_count = count_q;
  assign cmd_ovf   = ovf_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_slave = slave_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_valid = rsp_valid_q;
  assign busy      = (state_q != S_IDLE);
  assign din       = din_q;
  assign target    = target_q;
  assign trigger   = trigger_q;
  assign CPOL      = cpol_q;
  assign CPHA      = cpha_q;

endmodule

// File: tb/tb_spi_command_sequencer.sv
// Bench for spi_command_sequencer: transaction-level queue model checked every cycle,
// an spi_master stand-in returning ~din, and directed scenarios with literal expectations.
module tb_spi_command_sequencer;

  localparam int N       = 10;
  localparam int C       = 16;
  localparam int SW      = 4;
  localparam int AW      = 3;
  localparam int TIMEOUT = 4096;
  localparam int XFER    = 8;

  logic          CLK_IN = 1'b0;
  logic          RST_IN = 1'b1;
  logic [C-1:0]  cmd_data = '0;
  logic [SW-1:0] cmd_slave = '0;
  logic [1:0]    cmd_mode = '0;
  logic          cmd_wr = 1'b0;
  logic          cmd_full;
  logic [AW:0]   cmd_count;
  logic          cmd_ovf;
  logic [C-1:0]  rsp_data;
  logic [SW-1:0] rsp_slave;
  logic          rsp_err;
  logic          rsp_valid;
  logic          rsp_ready = 1'b1;
  logic          busy;
  logic [C-1:0]  din;
  logic [N-1:0]  target;
  logic          trigger;
  logic          CPOL;
  logic          CPHA;
  logic          valid = 1'b1;
  logic [C-1:0]  dout = '0;

  always #5 CLK_IN = ~CLK_IN;

  spi_command_sequencer #(
    .N(N), .C(C), .SW(SW), .AW(AW), .TIMEOUT(TIMEOUT)
  ) dut (
    .CLK_IN(CLK_IN), .RST_IN(RST_IN),
    .cmd_data(cmd_data), .cmd_slave(cmd_slave), .cmd_mode(cmd_mode), .cmd_wr(cmd_wr),
    .cmd_full(cmd_full), .cmd_count(cmd_count), .cmd_ovf(cmd_ovf),
    .rsp_data(rsp_data), .rsp_slave(rsp_slave), .rsp_err(rsp_err),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .busy(busy),
    .din(din), .target(target), .trigger(trigger), .CPOL(CPOL), .CPHA(CPHA),
    .valid(valid), .dout(dout)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge CLK_IN) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h cycle=%0d", name, act, exp, cyc);
    end
  endtask

  // spi_master stand-in: drops valid the edge after seeing trigger, returns ~din XFER edges later.
  bit           noack = 1'b0;
  logic [C-1:0] spi_din;
  initial begin
    forever begin
      @(negedge CLK_IN);
      if (trigger === 1'b1 && !noack) begin
        spi_din = din;
        @(posedge CLK_IN);
        #1 valid = 1'b0;
        repeat (XFER) @(posedge CLK_IN);
        #1;
        dout  = ~spi_din;
        valid = 1'b1;
      end
    end
  end

  // Behavioural model: queue of accepted commands plus the one in service.
  typedef struct {
    logic [SW-1:0] slave;
    logic [1:0]    mode;
    logic [C-1:0]  data;
  } cmd_t;

  cmd_t          mq[$];
  cmd_t          cur = '{default: '0};
  bit            m_busy = 1'b0;
  bit            m_ovf = 1'b0;
  bit            cur_noack = 1'b0;
  int            age = 0;
  bit            m_bad;
  bit            m_rv;
  int            m_exp_age;
  int            m_size0;
  logic [N-1:0]  m_tgt;
  logic [C-1:0]  m_rdata;

  int            trig_cnt = 0;
  int            rsp_cnt = 0;
  int            t_trig = 0;
  int            t_rsp = 0;
  bit            rv_prev = 1'b0;
  logic [N-1:0]  trig_target = '0;
  logic          trig_cpol = 1'b0;
  logic          trig_cpha = 1'b0;
  logic [C-1:0]  last_data = '0;
  logic [SW-1:0] last_slave = '0;
  logic          last_err = 1'b0;

  initial begin
    @(posedge CLK_IN);
    forever begin
      @(negedge CLK_IN);
      m_bad     = int'(cur.slave) >= N;
      m_exp_age = m_bad ? 1 : (cur_noack ? 2 + TIMEOUT : 4 + XFER);
      m_rv      = m_busy && (age >= m_exp_age);
      m_tgt     = (m_busy && !m_bad) ? (N'(1) << cur.slave) : '0;
      m_rdata   = (m_bad || cur_noack) ? '0 : ~cur.data;

      chk("cmd_count", 32'(cmd_count), 32'(mq.size()));
      chk("cmd_full", 32'(cmd_full), 32'(mq.size() == 8));
      chk("cmd_ovf", 32'(cmd_ovf), 32'(m_ovf));
      chk("busy", 32'(busy), 32'(m_busy));
      chk("target", 32'(target), 32'(m_tgt));
      chk("trigger", 32'(trigger), 32'(m_busy && !m_bad && age == 2));
      chk("rsp_valid", 32'(rsp_valid), 32'(m_rv));
      if (m_busy) begin
        chk("din", 32'(din), 32'(cur.data));
        chk("CPOL", 32'(CPOL), 32'(cur.mode[1]));
        chk("CPHA", 32'(CPHA), 32'(cur.mode[0]));
      end
      if (m_rv) begin
        chk("rsp_data", 32'(rsp_data), 32'(m_rdata));
        chk("rsp_err", 32'(rsp_err), 32'(m_bad || cur_noack));
        chk("rsp_slave", 32'(rsp_slave), 32'(cur.slave));
      end

      if (trigger === 1'b1) begin
        trig_cnt++;
        t_trig      = cyc;
        trig_target = target;
        trig_cpol   = CPOL;
        trig_cpha   = CPHA;
      end
      if (rsp_valid === 1'b1 && !rv_prev) t_rsp = cyc;
      rv_prev = (rsp_valid === 1'b1);

      if (RST_IN) begin
        mq.delete();
        m_busy = 1'b0;
        m_ovf  = 1'b0;
        age    = 0;
      end else begin
        m_size0 = mq.size();
        if (m_rv && rsp_ready) begin
          last_data  = rsp_data;
          last_slave = rsp_slave;
          last_err   = rsp_err;
          rsp_cnt++;
          m_busy = 1'b0;
          $display("rsp slave=%0d data=%h err=%0b cycle=%0d", rsp_slave, rsp_data, rsp_err, cyc);
        end else if (m_busy) begin
          age++;
        end else if (m_size0 > 0) begin
          cur       = mq.pop_front();
          cur_noack = noack;
          m_busy    = 1'b1;
          age       = 1;
        end
        if (cmd_wr) begin
          if (m_size0 < 8) mq.push_back('{cmd_slave, cmd_mode, cmd_data});
          else m_ovf = 1'b1;
        end
      end
    end
  end

  task automatic tick();
    @(posedge CLK_IN);
    #1;
  endtask

  task automatic push(input logic [SW-1:0] s, input logic [1:0] m, input logic [C-1:0] d);
    cmd_slave = s;
    cmd_mode  = m;
    cmd_data  = d;
    cmd_wr    = 1'b1;
    tick();
    cmd_wr = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n = 0;
    while (!(busy === 1'b0 && cmd_count === '0) && n < budget) begin
      tick();
      n++;
    end
    chk(name, 32'(busy !== 1'b0 || cmd_count !== '0), 32'(0));
  endtask

  task automatic wait_rsp(input int budget, input string name);
    int n = 0;
    while (rsp_valid !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    chk(name, 32'(rsp_valid), 32'(1));
  endtask

  task automatic wait_trig(input int budget, input string name);
    int n = 0;
    while (trigger !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    chk(name, 32'(trigger), 32'(1));
  endtask

  int           tab_slave[9] = '{0, 9, 1, 8, 2, 7, 4, 6, 3};
  int           t0;
  int           r0;
  logic [C-1:0] d0;

  initial begin
    repeat (3) @(posedge CLK_IN);
    #1 RST_IN = 1'b0;
    chk("rst_count", 32'(cmd_count), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_target", 32'(target), 32'(0));
    chk("rst_rsp_valid", 32'(rsp_valid), 32'(0));

    // Single command
    push(4'd3, 2'b10, 16'hA5C3);
    wait_idle(200, "single_done");
    chk("single_trig_target", 32'(trig_target), 32'(10'b0000001000));
    chk("single_trig_cpol", 32'(trig_cpol), 32'(1));
    chk("single_trig_cpha", 32'(trig_cpha), 32'(0));
    chk("single_rsp_data", 32'(last_data), 32'(16'h5A3C));
    chk("single_rsp_slave", 32'(last_slave), 32'(3));
    chk("single_rsp_err", 32'(last_err), 32'(0));
    chk("single_trig_cnt", 32'(trig_cnt), 32'(1));

    // Bad index
    t0 = trig_cnt;
    push(4'd12, 2'b01, 16'hFFFF);
    wait_idle(50, "bad_done");
    chk("bad_rsp_err", 32'(last_err), 32'(1));
    chk("bad_rsp_data", 32'(last_data), 32'(0));
    chk("bad_rsp_slave", 32'(last_slave), 32'(12));
    chk("bad_no_trigger", 32'(trig_cnt), 32'(t0));

    // Timeout, then a normal command
    noack = 1'b1;
    push(4'd7, 2'b11, 16'h0F0F);
    wait_idle(TIMEOUT + 100, "tmo_done");
    noack = 1'b0;
    chk("tmo_cycles", 32'(t_rsp - t_trig), 32'(4096));
    chk("tmo_rsp_err", 32'(last_err), 32'(1));
    chk("tmo_rsp_data", 32'(last_data), 32'(0));
    push(4'd0, 2'b00, 16'h8001);
    wait_idle(200, "after_tmo_done");
    chk("after_tmo_data", 32'(last_data), 32'(16'h7FFE));
    chk("after_tmo_err", 32'(last_err), 32'(0));

    // Backpressure with queue filling to overflow
    rsp_ready = 1'b0;
    push(4'd5, 2'b01, 16'h1234);
    wait_rsp(100, "bp_rsp_rise");
    d0 = rsp_data;
    chk("bp_rsp_data_lit", 32'(d0), 32'(16'hEDCB));
    t0 = trig_cnt;
    for (int i = 0; i < 9; i++) begin
      push(4'(tab_slave[i]), 2'(i), 16'(16'hC000 + i * 257));
      if (i == 7) begin
        chk("full_count", 32'(cmd_count), 32'(8));
        chk("full_flag", 32'(cmd_full), 32'(1));
        chk("full_no_ovf", 32'(cmd_ovf), 32'(0));
      end
    end
    chk("ovf_flag", 32'(cmd_ovf), 32'(1));
    chk("ovf_count", 32'(cmd_count), 32'(8));
    repeat (11) tick();
    chk("bp_rsp_hold", 32'(rsp_data), 32'(d0));
    chk("bp_rsp_valid", 32'(rsp_valid), 32'(1));
    chk("bp_no_trigger", 32'(trig_cnt), 32'(t0));
    r0 = rsp_cnt;
    rsp_ready = 1'b1;
    wait_idle(1000, "drain_done");
    chk("drain_rsp_cnt", 32'(rsp_cnt - r0), 32'(9));
    chk("drain_last_data", 32'(last_data), 32'(16'h38F8));
    chk("drain_last_slave", 32'(last_slave), 32'(6));

    // Reset during WAIT_DONE
    push(4'd6, 2'b10, 16'h5555);
    wait_trig(20, "rst_trig_seen");
    push(4'd1, 2'b00, 16'h0001);
    push(4'd2, 2'b00, 16'h0002);
    tick();
    r0 = rsp_cnt;
    RST_IN = 1'b1;
    tick();
    RST_IN = 1'b0;
    chk("midrst_trigger", 32'(trigger), 32'(0));
    chk("midrst_target", 32'(target), 32'(0));
    chk("midrst_busy", 32'(busy), 32'(0));
    chk("midrst_count", 32'(cmd_count), 32'(0));
    chk("midrst_ovf", 32'(cmd_ovf), 32'(0));
    repeat (30) tick();
    chk("midrst_no_rsp", 32'(rsp_cnt), 32'(r0));
    chk("midrst_rsp_valid", 32'(rsp_valid), 32'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
